// File: rtl/twos_complement_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// twos_complement_subtractor_pkg
//   Shared constants for the two's-complement subtractor slice.
//   SUB_WIDTH_DEF : default operand/result width used by the top module.
// -----------------------------------------------------------------------------
package twos_complement_subtractor_pkg;

  // Default operand width; legal range for the subtractor is 2..32.
  localparam int SUB_WIDTH_DEF = 4;

endpackage : twos_complement_subtractor_pkg

// File: rtl/twos_complement_subtractor_fa_cell.sv
// -----------------------------------------------------------------------------
// fa_cell
//   1-bit full adder, the building block of the subtractor's ripple chain.
//   Ports:
//     a    : input  1  addend bit
//     b    : input  1  addend bit (already inverted by the caller when subtracting)
//     cin  : input  1  carry in from the next-lower bit
//     s    : output 1  sum bit
//     cout : output 1  carry out to the next-higher bit
// -----------------------------------------------------------------------------
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;  // propagate

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule : fa_cell

// File: rtl/twos_complement_subtractor.sv
// -----------------------------------------------------------------------------
// twos_complement_subtractor
//   Computes a - b as a + ~b + 1 with a ripple chain of fa_cell instances and
//   registers the difference and carry-out in a single output stage.
//   Carry-out is the "no borrow" flag: 1 when a >= b (unsigned), 0 when a < b.
//   Ports:
//     clk       : input  1      clock, rising edge
//     rst_n     : input  1      asynchronous active-low reset
//     in_valid  : input  1      a/b valid this cycle; capture the difference
//     a         : input  WIDTH  minuend
//     b         : input  WIDTH  subtrahend
//     out_valid : output 1      high for the cycle after an in_valid capture
//     result    : output WIDTH  (a + ~b + 1) mod 2^WIDTH
//     carry     : output 1      carry-out of a + ~b + 1
// -----------------------------------------------------------------------------
module twos_complement_subtractor
  import twos_complement_subtractor_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  // Ripple chain: c[0] is the "+1" of the two's-complement negation of b.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] b_inv;
  logic [WIDTH-1:0] sum;

  assign c[0]  = 1'b1;
  assign b_inv = ~b;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_ripple
      fa_cell u_fa (
        .a    (a[gi]),
        .b    (b_inv[gi]),
        .cin  (c[gi]),
        .s    (sum[gi]),
        .cout (c[gi+1])
      );
    end
  endgenerate

  // Output register bank.
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q,  carry_d;
  logic             out_valid_q, out_valid_d;

  // Result and carry only load on in_valid, so a/b (even if unknown) are
  // ignored while idle and the last difference is held.
  always_comb begin
    result_d    = result_q;
    carry_d     = carry_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      result_d = sum;
      carry_d  = c[WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign carry     = carry_q;
  assign out_valid = out_valid_q;

endmodule : twos_complement_subtractor

// File: tb/tb_twos_complement_subtractor.sv
module tb_twos_complement_subtractor;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic [W-1:0] result;
  logic         carry;

  twos_complement_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .result    (result),
    .carry     (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic         c;
  } vec_t;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  logic [W-1:0] last_r;
  logic         last_c;

  task automatic check1(input string name, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  task automatic checkw(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of stimulus; a valid operation pushes its expected result.
  task automatic drive(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic v, input logic [W-1:0] er, input logic ec);
    exp_t e;
    @(negedge clk);
    a        = ta;
    b        = tb_v;
    in_valid = v;
    if (v) begin
      e.r = er;
      e.c = ec;
      sb_q.push_back(e);
      $display("drive a=%b b=%b -> expect result=%b carry=%b", ta, tb_v, er, ec);
    end
  endtask

  // Monitor: one cycle after each edge, out_valid must reflect the in_valid
  // seen at that edge; valid outputs pop the scoreboard, idle outputs hold.
  always @(posedge clk) begin : monitor
    logic exp_v;
    exp_t e;
    if (mon_en) begin
      exp_v = in_valid;
      #1;
      check1("out_valid", out_valid, exp_v);
      if (exp_v) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL scoreboard_empty: got output result=%b with no expected entry", result);
        end else begin
          e = sb_q.pop_front();
          checkw("result", result, e.r);
          check1("carry", carry, e.c);
          last_r = e.r;
          last_c = e.c;
        end
      end else begin
        checkw("hold_result", result, last_r);
        check1("hold_carry", carry, last_c);
      end
    end
  end

  vec_t vecs[11];

  initial begin
    logic [W-1:0] ma, mb, mr;
    logic [7:0]   j8;

    vecs[0]  = '{a: 4'b0101, b: 4'b0011, r: 4'b0010, c: 1'b1};
    vecs[1]  = '{a: 4'b0011, b: 4'b0101, r: 4'b1110, c: 1'b0};
    vecs[2]  = '{a: 4'b0000, b: 4'b0001, r: 4'b1111, c: 1'b0};
    vecs[3]  = '{a: 4'b0000, b: 4'b0000, r: 4'b0000, c: 1'b1};
    vecs[4]  = '{a: 4'b1111, b: 4'b1111, r: 4'b0000, c: 1'b1};
    vecs[5]  = '{a: 4'b1001, b: 4'b0000, r: 4'b1001, c: 1'b1};
    vecs[6]  = '{a: 4'b0000, b: 4'b1111, r: 4'b0001, c: 1'b0};
    vecs[7]  = '{a: 4'b1111, b: 4'b0000, r: 4'b1111, c: 1'b1};
    vecs[8]  = '{a: 4'b1000, b: 4'b0111, r: 4'b0001, c: 1'b1};
    vecs[9]  = '{a: 4'b0111, b: 4'b1000, r: 4'b1111, c: 1'b0};
    vecs[10] = '{a: 4'b0010, b: 4'b1101, r: 4'b0101, c: 1'b0};

    rst_n    = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;

    // Asynchronous reset asserted before any clock edge.
    #3 rst_n = 1'b0;
    #1;
    checkw("reset_result", result, '0);
    check1("reset_carry", carry, 1'b0);
    check1("reset_out_valid", out_valid, 1'b0);
    $display("reset check result=%b carry=%b out_valid=%b", result, carry, out_valid);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    last_r = '0;
    last_c = 1'b0;
    mon_en = 1'b1;

    // Directed table, back-to-back.
    for (int i = 0; i < 11; i++)
      drive(vecs[i].a, vecs[i].b, 1'b1, vecs[i].r, vecs[i].c);

    // Idle for 3 cycles: out_valid low, result/carry held.
    for (int i = 0; i < 3; i++)
      drive(4'b1010, 4'b0101, 1'b0, '0, 1'b0);

    // Exhaustive stream, back-to-back.
    for (int j = 0; j < 256; j++) begin
      j8 = j[7:0];
      ma = j8[7:4];
      mb = j8[3:0];
      mr = ma - mb;
      drive(ma, mb, 1'b1, mr, (ma >= mb));
    end

    // Unknown operands while idle must not disturb the held outputs.
    for (int i = 0; i < 3; i++)
      drive('x, 'x, 1'b0, '0, 1'b0);

    // Mid-stream reset discards the pending capture.
    drive(4'b0110, 4'b0100, 1'b1, 4'b0010, 1'b1);
    @(negedge clk);
    mon_en   = 1'b0;
    a        = 4'b0001;
    b        = 4'b0010;
    in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checkw("midreset_result", result, '0);
    check1("midreset_carry", carry, 1'b0);
    check1("midreset_out_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
    check1("inreset_out_valid", out_valid, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    check1("post_reset_out_valid", out_valid, 1'b0);
    checkw("post_reset_result", result, '0);
    $display("mid-stream reset check out_valid=%b result=%b", out_valid, result);
    sb_q.delete();
    last_r = '0;
    last_c = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    // Fresh operation after release, then idle.
    drive(4'b0111, 4'b0010, 1'b1, 4'b0101, 1'b1);
    drive(4'b0001, 4'b0100, 1'b1, 4'b1101, 1'b0);
    for (int i = 0; i < 3; i++)
      drive('0, '0, 1'b0, '0, 1'b0);
    @(negedge clk);
    mon_en = 1'b0;

    n_cmp++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_twos_complement_subtractor
